// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides and a registered result.
// Build option: define ALU_MUL_EN to add the iterative shift-add multiplier (op 1100).
module alu_mc #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ALU_MUL_EN
    , S_BUSY = 2'd2
`endif
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  ovf_q, ovf_d;
  logic                  cout_q, cout_d;
  logic                  zero_q, zero_d;

`ifdef ALU_MUL_EN
  localparam logic [3:0]       OP_MUL    = 4'b1100;
  localparam logic [SHAMT_W:0] MUL_STEPS = DATA_WIDTH[SHAMT_W:0];

  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [SHAMT_W:0]      cnt_q, cnt_d;
`endif

  logic                  sub_s;
  logic [DATA_WIDTH-1:0] opb_s;
  logic [DATA_WIDTH-1:0] sum_s;
  logic                  add_cout_s;
  logic                  add_ovf_s;
  logic [SHAMT_W-1:0]    shamt_s;
  logic [DATA_WIDTH-1:0] alu_res_s;
  logic                  alu_ovf_s;
  logic                  alu_cout_s;
  logic                  accept_s;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign CarryOut  = cout_q;
  assign Zero      = zero_q;

  // Single-cycle datapath: shared adder/subtractor, logic ops and shifter.
  always_comb begin
    sub_s     = (ALUop == OP_SUB) || (ALUop == OP_SLT) || (ALUop == OP_SLTU);
    opb_s     = sub_s ? ~B : B;
    {add_cout_s, sum_s} = {1'b0, A} + {1'b0, opb_s} + {{DATA_WIDTH{1'b0}}, sub_s};
    add_ovf_s = (A[DATA_WIDTH-1] == opb_s[DATA_WIDTH-1]) &&
                (sum_s[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
    shamt_s   = B[SHAMT_W-1:0];
    alu_res_s  = {DATA_WIDTH{1'b0}};
    alu_ovf_s  = 1'b0;
    alu_cout_s = 1'b0;
    case (ALUop)
      OP_AND: alu_res_s = A & B;
      OP_OR:  alu_res_s = A | B;
      OP_XOR: alu_res_s = A ^ B;
      OP_NOR: alu_res_s = ~(A | B);
      OP_ADD: begin
        alu_res_s  = sum_s;
        alu_ovf_s  = add_ovf_s;
        alu_cout_s = add_cout_s;
      end
      OP_SUB: begin
        alu_res_s  = sum_s;
        alu_ovf_s  = add_ovf_s;
        alu_cout_s = ~add_cout_s;
      end
      // Signed less-than corrects the difference's sign when the subtraction overflowed.
      OP_SLT: begin
        alu_res_s  = {{(DATA_WIDTH-1){1'b0}}, sum_s[DATA_WIDTH-1] ^ add_ovf_s};
        alu_cout_s = ~add_cout_s;
      end
      OP_SLTU: begin
        alu_res_s  = {{(DATA_WIDTH-1){1'b0}}, ~add_cout_s};
        alu_cout_s = ~add_cout_s;
      end
      OP_SLL:  alu_res_s = A << shamt_s;
      OP_SRL:  alu_res_s = A >> shamt_s;
      OP_SRA:  alu_res_s = $signed(A) >>> shamt_s;
      default: alu_res_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Next-state logic: handshake sequencing, result capture and multiplier iteration.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_d  = S_DONE;
          result_d = alu_res_s;
          ovf_d    = alu_ovf_s;
          cout_d   = alu_cout_s;
          zero_d   = (alu_res_s == {DATA_WIDTH{1'b0}});
`ifdef ALU_MUL_EN
          if (ALUop == OP_MUL) begin
            state_d  = S_BUSY;
            mcand_d  = A;
            mplier_d = B;
            acc_d    = {DATA_WIDTH{1'b0}};
            cnt_d    = {(SHAMT_W+1){1'b0}};
          end else begin
            state_d = S_DONE;
          end
`endif
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
`ifdef ALU_MUL_EN
      // One multiplier bit per step; the extra cycle after the last step publishes acc.
      S_BUSY: begin
        if (cnt_q == MUL_STEPS) begin
          state_d  = S_DONE;
          result_d = acc_q;
          ovf_d    = 1'b0;
          cout_d   = 1'b0;
          zero_d   = (acc_q == {DATA_WIDTH{1'b0}});
        end else begin
          cnt_d    = cnt_q + {{SHAMT_W{1'b0}}, 1'b1};
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      result_q <= {DATA_WIDTH{1'b0}};
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= {DATA_WIDTH{1'b0}};
      mplier_q <= {DATA_WIDTH{1'b0}};
      acc_q    <= {DATA_WIDTH{1'b0}};
      cnt_q    <= {(SHAMT_W+1){1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule
